// File: rtl/param_chain_pkg.sv
// Shared definitions for the parametrised skid-buffer chain: beat struct macro,
// default widths and the occupancy width helper.
`ifndef PARAM_CHAIN_BEAT_T
`define PARAM_CHAIN_BEAT_T(W) struct packed { logic valid; logic [(W)-1:0] data; }
`endif

package param_chain_pkg;

    localparam int STALL_CNT_WIDTH_DEFAULT = 16;

    // Width needed to count 0..2*n held beats.
    function automatic int occ_width(input int n);
        return $clog2(2 * n + 1);
    endfunction

endpackage

// File: rtl/param_chain_if.sv
// Producer/consumer handshake bundle for the chain; master is the environment,
// slave is the chain itself.
interface param_chain_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/chain_skid_stage.sv
// One two-entry skid buffer; upstream ready comes straight from a register so
// ready never combinationally crosses a stage.
module chain_skid_stage #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  main_clock,
    input  logic                  main_reset,
    input  logic                  flush,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] up_data,
    output logic                  down_valid,
    input  logic                  down_ready,
    output logic [DATA_WIDTH-1:0] down_data
);
    typedef `PARAM_CHAIN_BEAT_T(DATA_WIDTH) beat_t;

    beat_t main_q;
    beat_t skid_q;
    logic  up_fire;
    logic  down_fire;

    assign up_ready   = !skid_q.valid;
    assign up_fire    = up_valid && up_ready;
    assign down_valid = main_q.valid;
    assign down_data  = main_q.data;
    assign down_fire  = main_q.valid && down_ready;

    // Skid always drains into main first so beat order is preserved.
    always_ff @(posedge main_clock or negedge main_reset) begin
        if (!main_reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_q.valid <= 1'b0;
            skid_q.valid <= 1'b0;
        end else if (!main_q.valid || down_fire) begin
            if (skid_q.valid) begin
                main_q       <= skid_q;
                skid_q.valid <= up_fire;
                if (up_fire) begin
                    skid_q.data <= up_data;
                end
            end else if (up_fire) begin
                main_q.valid <= 1'b1;
                main_q.data  <= up_data;
            end else begin
                main_q.valid <= 1'b0;
            end
        end else if (up_fire) begin
            skid_q.valid <= 1'b1;
            skid_q.data  <= up_data;
        end
    end
endmodule

// File: rtl/param_chain_system.sv
// NUM_STAGES skid stages chained by valid/ready, plus occupancy tracking,
// a saturating stall counter and a registered busy flag.
module param_chain_system
    import param_chain_pkg::*;
#(
    parameter int NUM_STAGES      = 3,
    parameter int DATA_WIDTH      = 8,
    parameter int STALL_CNT_WIDTH = STALL_CNT_WIDTH_DEFAULT
) (
    input  logic                                main_clock,
    input  logic                                main_reset,
    input  logic                                flush,
    param_chain_if.slave                        bus,
    output logic [occ_width(NUM_STAGES)-1:0]    occupancy,
    output logic [STALL_CNT_WIDTH-1:0]          stall_count,
    output logic                                system_output
);
    localparam int OCC_W = occ_width(NUM_STAGES);

    logic                  link_valid [NUM_STAGES+1];
    logic                  link_ready [NUM_STAGES+1];
    logic [DATA_WIDTH-1:0] link_data  [NUM_STAGES+1];

    logic             in_fire;
    logic             out_fire;
    logic [OCC_W-1:0] occ_next;

    assign link_valid[0]          = bus.in_valid;
    assign link_data[0]           = bus.in_data;
    assign bus.in_ready           = link_ready[0];
    assign link_ready[NUM_STAGES] = bus.out_ready;
    assign bus.out_valid          = link_valid[NUM_STAGES];
    assign bus.out_data           = link_data[NUM_STAGES];

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        chain_skid_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .main_clock (main_clock),
            .main_reset (main_reset),
            .flush      (flush),
            .up_valid   (link_valid[k]),
            .up_ready   (link_ready[k]),
            .up_data    (link_data[k]),
            .down_valid (link_valid[k+1]),
            .down_ready (link_ready[k+1]),
            .down_data  (link_data[k+1])
        );
    end

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    // Beats crossing the boundary during a flush are discarded with everything else.
    always_comb begin
        occ_next = '0;
        if (!flush) begin
            occ_next = occupancy + OCC_W'(in_fire) - OCC_W'(out_fire);
        end
    end

    always_ff @(posedge main_clock or negedge main_reset) begin
        if (!main_reset) begin
            occupancy     <= '0;
            system_output <= 1'b0;
        end else begin
            occupancy     <= occ_next;
            system_output <= (occ_next != '0);
        end
    end

    always_ff @(posedge main_clock or negedge main_reset) begin
        if (!main_reset) begin
            stall_count <= '0;
        end else if (bus.out_valid && !bus.out_ready && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_param_chain_system.sv
// Directed bench for param_chain_system (3 stages, 8-bit data, 4-bit stall
// counter so saturation is reachable) with a queue scoreboard.
module tb_param_chain_system;
    localparam int NS      = 3;
    localparam int DW      = 8;
    localparam int SW      = 4;
    localparam int STALL_MAX = (1 << SW) - 1;

    logic          main_clock;
    logic          main_reset;
    logic          flush;
    logic [2:0]    occupancy;
    logic [SW-1:0] stall_count;
    logic          system_output;

    param_chain_if #(.DATA_WIDTH(DW)) bus_if ();

    param_chain_system #(
        .NUM_STAGES      (NS),
        .DATA_WIDTH      (DW),
        .STALL_CNT_WIDTH (SW)
    ) dut (
        .main_clock    (main_clock),
        .main_reset    (main_reset),
        .flush         (flush),
        .bus           (bus_if),
        .occupancy     (occupancy),
        .stall_count   (stall_count),
        .system_output (system_output)
    );

    initial main_clock = 1'b0;
    always #5 main_clock = ~main_clock;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] sb [$];
    int  model_stall;
    logic obs_in_fire, obs_out_fire, obs_out_valid;
    logic [2:0] obs_occ;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyReset();
        main_reset       = 1'b0;
        flush            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        sb.delete();
        model_stall = 0;
        repeat (2) @(posedge main_clock);
        @(negedge main_clock);
        main_reset = 1'b1;
    endtask

    // One clock: drive at the negedge, score what fires at the posedge, check at the next negedge.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic ordy, input logic fl);
        logic [DW-1:0] exp_data;
        bus_if.in_valid  = v;
        bus_if.in_data   = d;
        bus_if.out_ready = ordy;
        flush            = fl;
        obs_in_fire   = bus_if.in_valid & bus_if.in_ready;
        obs_out_fire  = bus_if.out_valid & bus_if.out_ready;
        obs_out_valid = bus_if.out_valid;
        obs_occ       = occupancy;
        if (obs_out_fire) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out", 32'(bus_if.out_data), 32'hFFFF_FFFF);
            end else begin
                exp_data = sb.pop_front();
                checkOutput("out_data", 32'(bus_if.out_data), 32'(exp_data));
            end
        end
        if (bus_if.out_valid && !bus_if.out_ready && model_stall < STALL_MAX) model_stall++;
        if (fl) sb.delete();
        else if (obs_in_fire) sb.push_back(d);
        @(posedge main_clock);
        @(negedge main_clock);
        checkOutput("occupancy", 32'(occupancy), 32'(sb.size()));
        checkOutput("busy", 32'(system_output), 32'(sb.size() != 0));
        checkOutput("stall_count", 32'(stall_count), 32'(model_stall));
    endtask

    initial begin
        int pushed, first_in, first_out, last_out, out_cnt, acc, stall_before;

        applyReset();
        checkOutput("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus_if.out_data), 32'd0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'd0);
        checkOutput("rst_stall", 32'(stall_count), 32'd0);
        checkOutput("rst_busy", 32'(system_output), 32'd0);

        $display("[TB] stream 0x01..0x0A with out_ready=1");
        pushed = 0; first_in = -1; first_out = -1; last_out = -1; out_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            applyStimulus(pushed < 10, DW'(pushed + 1), 1'b1, 1'b0);
            if (obs_in_fire) begin
                if (first_in < 0) first_in = i;
                pushed++;
            end
            if (obs_out_valid && first_out < 0) begin
                first_out = i;
                checkOutput("occ_at_first_out", 32'(obs_occ), 32'd3);
            end
            if (obs_out_fire) begin
                out_cnt++;
                last_out = i;
            end
        end
        checkOutput("latency", 32'(first_out - first_in), 32'd3);
        checkOutput("stream_count", 32'(out_cnt), 32'd10);
        checkOutput("no_bubbles", 32'(last_out - first_out), 32'd9);

        $display("[TB] fill with out_ready=0");
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, DW'(acc + 1), 1'b0, 1'b0);
            if (obs_in_fire) begin
                acc++;
                if (acc == 6) checkOutput("in_ready_after_6th", 32'(bus_if.in_ready), 32'd0);
            end
        end
        checkOutput("fill_accepted", 32'(acc), 32'd6);
        checkOutput("fill_occupancy", 32'(occupancy), 32'd6);
        checkOutput("fill_in_ready", 32'(bus_if.in_ready), 32'd0);

        $display("[TB] drain after fill");
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            if (k <= 6) checkOutput("drain_out_valid", 32'(obs_out_valid), 32'd1);
            if (k == 1) checkOutput("drain_in_ready_k1", 32'(bus_if.in_ready), 32'd0);
            if (k == 3) checkOutput("drain_in_ready_k3", 32'(bus_if.in_ready), 32'd1);
        end
        checkOutput("drain_occupancy", 32'(occupancy), 32'd0);
        checkOutput("drain_busy", 32'(system_output), 32'd0);

        $display("[TB] flush mid-stream");
        applyReset();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(8'hA1 + i), 1'b0, 1'b0);
        checkOutput("pre_flush_occ", 32'(occupancy), 32'd4);
        stall_before = int'(stall_count);
        applyStimulus(1'b1, 8'h55, 1'b1, 1'b1);
        checkOutput("flush_in_fire", 32'(obs_in_fire), 32'd1);
        checkOutput("flush_occ", 32'(occupancy), 32'd0);
        checkOutput("flush_out_valid", 32'(bus_if.out_valid), 32'd0);
        checkOutput("flush_stall_kept", 32'(stall_count), 32'(stall_before));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("post_flush_idle", 32'(bus_if.out_valid), 32'd0);
        end

        $display("[TB] random backpressure");
        for (int i = 0; i < 2000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 30 && sb.size() != 0; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("random_drained", 32'(sb.size()), 32'd0);
        checkOutput("random_occ_zero", 32'(occupancy), 32'd0);

        $display("[TB] stall saturation and async reset");
        applyReset();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
        checkOutput("stall_saturated", 32'(stall_count), 32'(STALL_MAX));
        checkOutput("pre_reset_valid", 32'(bus_if.out_valid), 32'd1);
        @(posedge main_clock);
        #2;
        main_reset = 1'b0;
        #1;
        checkOutput("async_in_ready", 32'(bus_if.in_ready), 32'd1);
        checkOutput("async_out_valid", 32'(bus_if.out_valid), 32'd0);
        checkOutput("async_out_data", 32'(bus_if.out_data), 32'd0);
        checkOutput("async_occupancy", 32'(occupancy), 32'd0);
        checkOutput("async_stall", 32'(stall_count), 32'd0);
        checkOutput("async_busy", 32'(system_output), 32'd0);
        @(negedge main_clock);
        main_reset = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
